dcache_controller: RTL and testbench

- Direct-mapped, write-back, write-allocate data cache controller between the CPU load/store port and the word-fetch/write-back data memory.
- Holds tag/valid/dirty/data arrays; on a miss it stalls the CPU, writes back the dirty victim, then fetches the new word over a fixed-latency memory interface.
- MMIO trigger address bypasses the cache entirely.

---
 rtl/dcache_controller.sv | 163 ++++++++++++++++
 tb/tb_dcache_controller.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/dcache_controller.sv
// Direct-mapped, write-back, write-allocate data cache controller with MMIO bypass.
// Define CACHE_STATS_EN to build the saturating hit/miss counters.
module dcache_controller #(
  parameter int                    DATA_WIDTH  = 32,
  parameter int                    ADDR_WIDTH  = 32,
  parameter int                    SETS        = 256,
  parameter int                    MEM_LATENCY = 2,
  parameter logic [ADDR_WIDTH-1:0] MMIO_ADDR   = 32'h000000FC
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req_valid,
  input  logic                    req_we,
  input  logic [ADDR_WIDTH-1:0]   req_addr,
  input  logic [DATA_WIDTH/8-1:0] req_be,
  input  logic [DATA_WIDTH-1:0]   req_wdata,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic                    stall,
  output logic                    mem_fetch,
  output logic                    mem_writeback,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  output logic [ADDR_WIDTH-1:0]   mem_wb_addr,
  output logic [DATA_WIDTH-1:0]   mem_wb_data,
  input  logic [DATA_WIDTH-1:0]   mem_rdata,
  output logic [31:0]             hit_count,
  output logic [31:0]             miss_count
);

  localparam int IDX_W = $clog2(SETS);
  localparam int TAG_W = ADDR_WIDTH - IDX_W - 2;
  localparam int BE_W  = DATA_WIDTH / 8;
  localparam int CNT_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_LATENCY - 1);

  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] WRITEBACK = 2'd1;
  localparam logic [1:0] FETCH     = 2'd2;

  logic [1:0]            state;
  logic [CNT_W-1:0]      cnt;
  logic [SETS-1:0]       valid;
  logic [SETS-1:0]       dirty;
  logic [TAG_W-1:0]      tags [SETS];
  logic [DATA_WIDTH-1:0] data [SETS];

  logic [IDX_W-1:0]      fill_idx;
  logic [TAG_W-1:0]      fill_tag;

  logic [IDX_W-1:0]      idx;
  logic [TAG_W-1:0]      tag;
  logic                  is_mmio;
  logic                  hit;
  logic                  cached_req;
  logic                  store_hit;
  logic                  miss;
  logic                  fill_done;
  logic [DATA_WIDTH-1:0] merged;

  assign idx        = req_addr[IDX_W+1:2];
  assign tag        = req_addr[ADDR_WIDTH-1:IDX_W+2];
  assign is_mmio    = (req_addr == MMIO_ADDR);
  assign hit        = valid[idx] && (tags[idx] == tag);
  assign cached_req = (state == IDLE) && req_valid && !is_mmio;
  assign store_hit  = cached_req && hit && req_we;
  assign miss       = cached_req && !hit;
  assign fill_done  = (state == FETCH) && (cnt == CNT_LAST);

  assign stall         = (state != IDLE) || miss;
  assign mem_fetch     = (state == FETCH);
  assign mem_writeback = (state == WRITEBACK);
  assign mem_addr      = (state == FETCH) ? {fill_tag, fill_idx, 2'b00} : req_addr;

  always_comb begin
    merged = data[idx];
    for (int unsigned b = 0; b < BE_W; b++) begin
      if (req_be[b]) merged[b*8 +: 8] = req_wdata[b*8 +: 8];
    end
  end

  always_comb begin
    rsp_rdata = '0;
    if ((state == IDLE) && req_valid) begin
      if (is_mmio)  rsp_rdata = mem_rdata;
      else if (hit) rsp_rdata = data[idx];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      valid       <= '0;
      dirty       <= '0;
      fill_idx    <= '0;
      fill_tag    <= '0;
      mem_wb_addr <= '0;
      mem_wb_data <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (store_hit) dirty[idx] <= 1'b1;
          if (miss) begin
            // Victim is captured at detection so the write-back cycle needs no array read.
            fill_idx    <= idx;
            fill_tag    <= tag;
            mem_wb_addr <= {tags[idx], idx, 2'b00};
            mem_wb_data <= data[idx];
            cnt         <= '0;
            state       <= (valid[idx] && dirty[idx]) ? WRITEBACK : FETCH;
          end
        end
        WRITEBACK: begin
          cnt   <= '0;
          state <= FETCH;
        end
        FETCH: begin
          if (fill_done) begin
            valid[fill_idx] <= 1'b1;
            dirty[fill_idx] <= 1'b0;
            cnt             <= '0;
            state           <= IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Tag and data arrays carry no reset; valid bits gate their use.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (store_hit) data[idx] <= merged;
      if (fill_done) begin
        data[fill_idx] <= mem_rdata;
        tags[fill_idx] <= fill_tag;
      end
    end
  end

`ifdef CACHE_STATS_EN
  logic [31:0] hits;
  logic [31:0] misses;

  always_ff @(posedge clk) begin
    if (rst) begin
      hits   <= '0;
      misses <= '0;
    end else begin
      if (cached_req && hit && (hits != '1))  hits   <= hits + 1'b1;
      if (miss && (misses != '1))             misses <= misses + 1'b1;
    end
  end

  assign hit_count  = hits;
  assign miss_count = misses;
`else
  assign hit_count  = '0;
  assign miss_count = '0;
`endif

endmodule

// File: tb/tb_dcache_controller.sv
// Directed self-checking bench for dcache_controller (default parameters).
module tb_dcache_controller;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_we = 1'b0;
  logic [31:0] req_addr = '0;
  logic [3:0]  req_be = '0;
  logic [31:0] req_wdata = '0;
  logic [31:0] rsp_rdata;
  logic        stall;
  logic        mem_fetch;
  logic        mem_writeback;
  logic [31:0] mem_addr;
  logic [31:0] mem_wb_addr;
  logic [31:0] mem_wb_data;
  logic [31:0] mem_rdata = '0;
  logic [31:0] hit_count;
  logic [31:0] miss_count;

  int errors = 0;
  int checks = 0;

  dcache_controller #(
    .DATA_WIDTH (32),
    .ADDR_WIDTH (32),
    .SETS       (256),
    .MEM_LATENCY(2),
    .MMIO_ADDR  (32'h000000FC)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_we       (req_we),
    .req_addr     (req_addr),
    .req_be       (req_be),
    .req_wdata    (req_wdata),
    .rsp_rdata    (rsp_rdata),
    .stall        (stall),
    .mem_fetch    (mem_fetch),
    .mem_writeback(mem_writeback),
    .mem_addr     (mem_addr),
    .mem_wb_addr  (mem_wb_addr),
    .mem_wb_data  (mem_wb_data),
    .mem_rdata    (mem_rdata),
    .hit_count    (hit_count),
    .miss_count   (miss_count)
  );

  always #5 clk = ~clk;

  // Step to the drive point just after the next rising edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Walks a stalled access until stall drops, recording strobe activity (stalls=-1 on timeout).
  task automatic wait_access(input logic [31:0] exp_faddr, output int stalls, output int fetches,
                             output int wbs, output logic [31:0] wb_addr,
                             output logic [31:0] wb_data, output int bad);
    stalls = 0; fetches = 0; wbs = 0; bad = 0; wb_addr = '0; wb_data = '0;
    for (int i = 0; i < 20; i++) begin
      if (!stall) return;
      stalls++;
      if (mem_fetch) begin
        fetches++;
        if (mem_addr !== exp_faddr) bad++;
      end
      if (mem_writeback) begin
        wbs++;
        wb_addr = mem_wb_addr;
        wb_data = mem_wb_data;
      end
      if (mem_fetch && mem_writeback) bad++;
      @(posedge clk);
      #2;
    end
    stalls = -1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cyc(); cyc();
    rst = 1'b0;
    #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b expected 0", stall); end
    checks++; if (mem_fetch !== 1'b0) begin errors++; $display("FAIL reset_fetch: got %b expected 0", mem_fetch); end
    checks++; if (mem_writeback !== 1'b0) begin errors++; $display("FAIL reset_wb: got %b expected 0", mem_writeback); end
    checks++; if (mem_wb_addr !== 32'h0) begin errors++; $display("FAIL reset_wb_addr: got %h expected 0", mem_wb_addr); end
    checks++; if (mem_wb_data !== 32'h0) begin errors++; $display("FAIL reset_wb_data: got %h expected 0", mem_wb_data); end
    checks++; if (rsp_rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata: got %h expected 0", rsp_rdata); end
    checks++; if (hit_count !== 32'h0 || miss_count !== 32'h0) begin errors++;
      $display("FAIL reset_counts: got hit=%0d miss=%0d expected 0/0", hit_count, miss_count); end
  endtask

  task automatic test_load_miss();
    int s, f, w, bad;
    logic [31:0] wa, wd;
    cyc();
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h00010000; mem_rdata = 32'hDEADBEEF;
    #1;
    wait_access(32'h00010000, s, f, w, wa, wd, bad);
    checks++; if (s !== 3) begin errors++; $display("FAIL miss_stalls: got %0d expected 3", s); end
    checks++; if (f !== 2) begin errors++; $display("FAIL miss_fetches: got %0d expected 2", f); end
    checks++; if (w !== 0 || bad !== 0) begin errors++; $display("FAIL miss_strobes: got wb=%0d bad=%0d expected 0/0", w, bad); end
    checks++; if (rsp_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL miss_rdata: got %h expected deadbeef", rsp_rdata); end
  endtask

  task automatic test_store_hit();
    cyc();
    req_we = 1'b1; req_be = 4'b0001; req_wdata = 32'h000000AA;
    #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL store_stall: got %b expected 0", stall); end
    cyc();
    req_we = 1'b0; req_be = 4'b0000;
    #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL store_reload_stall: got %b expected 0", stall); end
    checks++; if (rsp_rdata !== 32'hDEADBEAA) begin errors++; $display("FAIL store_merge: got %h expected deadbeaa", rsp_rdata); end
  endtask

  task automatic test_dirty_evict();
    int s, f, w, bad;
    logic [31:0] wa, wd;
    cyc();
    req_addr = 32'h00010400; mem_rdata = 32'h12345678;
    #1;
    wait_access(32'h00010400, s, f, w, wa, wd, bad);
    checks++; if (s !== 4) begin errors++; $display("FAIL evict_stalls: got %0d expected 4", s); end
    checks++; if (w !== 1 || f !== 2 || bad !== 0) begin errors++;
      $display("FAIL evict_strobes: got wb=%0d fetch=%0d bad=%0d expected 1/2/0", w, f, bad); end
    checks++; if (wa !== 32'h00010000) begin errors++; $display("FAIL evict_wb_addr: got %h expected 00010000", wa); end
    checks++; if (wd !== 32'hDEADBEAA) begin errors++; $display("FAIL evict_wb_data: got %h expected deadbeaa", wd); end
    checks++; if (rsp_rdata !== 32'h12345678) begin errors++; $display("FAIL evict_rdata: got %h expected 12345678", rsp_rdata); end
    // Evicting the now-clean line must not write back.
    cyc();
    req_addr = 32'h00010000; mem_rdata = 32'hCAFEF00D;
    #1;
    wait_access(32'h00010000, s, f, w, wa, wd, bad);
    checks++; if (s !== 3 || w !== 0 || bad !== 0) begin errors++;
      $display("FAIL clean_evict: got stalls=%0d wb=%0d bad=%0d expected 3/0/0", s, w, bad); end
    checks++; if (rsp_rdata !== 32'hCAFEF00D) begin errors++; $display("FAIL clean_rdata: got %h expected cafef00d", rsp_rdata); end
  endtask

  task automatic test_mmio();
    cyc();
    req_addr = 32'h000000FC; mem_rdata = 32'h00000001;
    #1;
    checks++; if (stall !== 1'b0 || mem_fetch !== 1'b0) begin errors++;
      $display("FAIL mmio_load_stall: got stall=%b fetch=%b expected 0/0", stall, mem_fetch); end
    checks++; if (rsp_rdata !== 32'h00000001) begin errors++; $display("FAIL mmio_rdata: got %h expected 00000001", rsp_rdata); end
    checks++; if (mem_addr !== 32'h000000FC) begin errors++; $display("FAIL mmio_addr: got %h expected 000000fc", mem_addr); end
    cyc();
    req_we = 1'b1; req_be = 4'hF; req_wdata = 32'h55555555;
    #1;
    checks++; if (stall !== 1'b0 || mem_fetch !== 1'b0 || mem_writeback !== 1'b0) begin errors++;
      $display("FAIL mmio_store: got stall=%b fetch=%b wb=%b expected 0/0/0", stall, mem_fetch, mem_writeback); end
    cyc();
    req_valid = 1'b0; req_we = 1'b0; req_be = 4'h0;
    #1;
    checks++; if (mem_fetch !== 1'b0 || mem_writeback !== 1'b0) begin errors++;
      $display("FAIL mmio_after: got fetch=%b wb=%b expected 0/0", mem_fetch, mem_writeback); end
  endtask

  task automatic test_reset_mid_fetch();
    int s, f, w, bad;
    logic [31:0] wa, wd;
    cyc();
    req_valid = 1'b1; req_addr = 32'h00020000; mem_rdata = 32'h11111111;
    #1;
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL abort_miss_stall: got %b expected 1", stall); end
    cyc();
    #1;
    checks++; if (mem_fetch !== 1'b1) begin errors++; $display("FAIL abort_fetch_on: got %b expected 1", mem_fetch); end
    rst = 1'b1; req_valid = 1'b0;
    cyc();
    rst = 1'b0;
    #1;
    checks++; if (stall !== 1'b0 || mem_fetch !== 1'b0) begin errors++;
      $display("FAIL abort_idle: got stall=%b fetch=%b expected 0/0", stall, mem_fetch); end
    cyc();
    req_valid = 1'b1; req_addr = 32'h00010000; mem_rdata = 32'hABCD0123;
    #1;
    wait_access(32'h00010000, s, f, w, wa, wd, bad);
    checks++; if (s !== 3 || w !== 0) begin errors++;
      $display("FAIL abort_remiss: got stalls=%0d wb=%0d expected 3/0", s, w); end
    checks++; if (rsp_rdata !== 32'hABCD0123) begin errors++; $display("FAIL abort_rdata: got %h expected abcd0123", rsp_rdata); end
  endtask

  task automatic test_stats();
    int s, f, w, bad;
    logic [31:0] wa, wd;
    logic [31:0] exp_hits, exp_misses;
`ifdef CACHE_STATS_EN
    exp_hits = 32'd3; exp_misses = 32'd1;
`else
    exp_hits = 32'd0; exp_misses = 32'd0;
`endif
    cyc();
    req_valid = 1'b0; rst = 1'b1;
    cyc();
    rst = 1'b0; req_valid = 1'b1; req_addr = 32'h00030000; mem_rdata = 32'h00000077;
    #1;
    wait_access(32'h00030000, s, f, w, wa, wd, bad);
    cyc(); cyc(); cyc();
    req_valid = 1'b0;
    #1;
    checks++; if (miss_count !== exp_misses) begin errors++; $display("FAIL stats_miss: got %0d expected %0d", miss_count, exp_misses); end
    checks++; if (hit_count !== exp_hits) begin errors++; $display("FAIL stats_hit: got %0d expected %0d", hit_count, exp_hits); end
  endtask

  initial begin
    test_reset();
    test_load_miss();
    test_store_hit();
    test_dirty_evict();
    test_mmio();
    test_reset_mid_fetch();
    test_stats();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
